// File: rtl/seq_detect_param_if.sv
// Serial-bit detector bus: qualified bit stream and controls in, match pulse and status out.
interface seq_detect_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic               i_seq;
  logic               i_valid;
  logic               i_overlap;
  logic [PAT_LEN-1:0] i_pat;
  logic               i_pat_load;
  logic               i_cnt_clr;
  logic               o_match;
  logic [CNT_W-1:0]   o_match_cnt;
  logic [FILL_W-1:0]  o_fill;

  modport master (
    output i_seq, i_valid, i_overlap, i_pat, i_pat_load, i_cnt_clr,
    input  o_match, o_match_cnt, o_fill
  );

  modport slave (
    input  i_seq, i_valid, i_overlap, i_pat, i_pat_load, i_cnt_clr,
    output o_match, o_match_cnt, o_fill
  );
endinterface

// File: rtl/seq_detect_param.sv
// Moore detector for a run-time-loadable PAT_LEN-bit serial pattern, with overlap control
// and a saturating match counter. Built as history + fill level instead of a per-pattern FSM.
module seq_detect_param #(
  parameter int          PAT_LEN = 4,
  parameter int          CNT_W   = 8,
  parameter logic [15:0] PAT_RST = 16'h000B
) (
  input  logic               i_clk,
  input  logic               i_rst,
  seq_detect_param_if.slave  bus
);
  localparam int                 FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [PAT_LEN-1:0] PAT_INIT  = PAT_RST[PAT_LEN-1:0];
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic [PAT_LEN-1:0] pat_q,  pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  logic [PAT_LEN-1:0] hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               hit;

  always_comb begin
    hist_shift = {hist_q[PAT_LEN-2:0], bus.i_seq};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit        = (fill_inc == FILL_FULL) && (hist_shift == pat_q);

    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    // A pattern load wins over a same-cycle bit, which is dropped.
    if (bus.i_pat_load) begin
      pat_d  = bus.i_pat;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.i_valid) begin
      hist_d  = hist_shift;
      fill_d  = (hit && !bus.i_overlap) ? '0 : fill_inc;
      match_d = hit;
    end

    if (bus.i_cnt_clr) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pat_q   <= PAT_INIT;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_match     = match_q;
  assign bus.o_match_cnt = cnt_q;
  assign bus.o_fill      = fill_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param (PAT_LEN=4, CNT_W=2, reset pattern 1011).
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_LEN(4), .CNT_W(2)) bus ();

  seq_detect_param #(.PAT_LEN(4), .CNT_W(2), .PAT_RST(16'h000B)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.i_seq      = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_pat      = 4'b0000;
    bus.i_pat_load = 1'b0;
    bus.i_cnt_clr  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic b);
    bus.i_valid = 1'b1;
    bus.i_seq   = b;
    tick();
    bus.i_valid = 1'b0;
    bus.i_seq   = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] stream;
    logic [3:0] exp_m;
    bus.i_overlap = 1'b1;
    idle_inputs();
    do_reset(4);
    if (bus.o_match !== 1'b0) begin
      $display("FAIL rst_match got %b exp 0", bus.o_match); n_fail++;
    end
    n_checks++;
    if (bus.o_match_cnt !== 2'd0) begin
      $display("FAIL rst_cnt got %0d exp 0", bus.o_match_cnt); n_fail++;
    end
    n_checks++;
    if (bus.o_fill !== 3'd0) begin
      $display("FAIL rst_fill got %0d exp 0", bus.o_fill); n_fail++;
    end
    n_checks++;
    // Reset pattern must be 1011: only the fourth bit completes it.
    stream = 4'b1011;
    exp_m  = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      send(stream[3-i]);
      if (bus.o_match !== exp_m[3-i]) begin
        $display("FAIL rst_pat bit%0d got %b exp %b", i, bus.o_match, exp_m[3-i]); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_overlap();
    logic [6:0] stream;
    logic [6:0] exp_m;
    do_reset(1);
    bus.i_overlap = 1'b1;
    stream = 7'b1011011;
    exp_m  = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      send(stream[6-i]);
      if (bus.o_match !== exp_m[6-i]) begin
        $display("FAIL ovl_match bit%0d got %b exp %b", i, bus.o_match, exp_m[6-i]); n_fail++;
      end
      n_checks++;
    end
    if (bus.o_match_cnt !== 2'd2) begin
      $display("FAIL ovl_cnt got %0d exp 2", bus.o_match_cnt); n_fail++;
    end
    n_checks++;
    tick();
    if (bus.o_match !== 1'b0) begin
      $display("FAIL ovl_idle_match got %b exp 0", bus.o_match); n_fail++;
    end
    n_checks++;
    if (bus.o_fill !== 3'd4) begin
      $display("FAIL ovl_fill got %0d exp 4", bus.o_fill); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_nonoverlap();
    logic [6:0] stream;
    logic [6:0] exp_m;
    do_reset(1);
    bus.i_overlap = 1'b0;
    stream = 7'b1011011;
    exp_m  = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      send(stream[6-i]);
      if (bus.o_match !== exp_m[6-i]) begin
        $display("FAIL novl_match bit%0d got %b exp %b", i, bus.o_match, exp_m[6-i]); n_fail++;
      end
      n_checks++;
    end
    if (bus.o_match_cnt !== 2'd1) begin
      $display("FAIL novl_cnt got %0d exp 1", bus.o_match_cnt); n_fail++;
    end
    n_checks++;
    if (bus.o_fill !== 3'd3) begin
      $display("FAIL novl_fill got %0d exp 3", bus.o_fill); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_gaps();
    logic [3:0] stream;
    do_reset(1);
    bus.i_overlap = 1'b1;
    stream = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      send(stream[3-i]);
      if (bus.o_match !== (i == 3)) begin
        $display("FAIL gap_match bit%0d got %b exp %b", i, bus.o_match, (i == 3)); n_fail++;
      end
      n_checks++;
      for (int g = 0; g < 3; g++) begin
        tick();
        if (bus.o_match !== 1'b0) begin
          $display("FAIL gap_idle bit%0d gap%0d got %b exp 0", i, g, bus.o_match); n_fail++;
        end
        n_checks++;
      end
      if (bus.o_fill !== 3'(i + 1)) begin
        $display("FAIL gap_fill bit%0d got %0d exp %0d", i, bus.o_fill, i + 1); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_reload();
    logic [3:0] stream;
    logic [3:0] exp_m;
    do_reset(1);
    bus.i_overlap = 1'b1;
    send(1'b1);
    send(1'b0);
    // Valid bit alongside the load must be discarded.
    bus.i_pat      = 4'b0110;
    bus.i_pat_load = 1'b1;
    bus.i_valid    = 1'b1;
    bus.i_seq      = 1'b1;
    tick();
    idle_inputs();
    if (bus.o_fill !== 3'd0) begin
      $display("FAIL load_fill got %0d exp 0", bus.o_fill); n_fail++;
    end
    n_checks++;
    if (bus.o_match !== 1'b0) begin
      $display("FAIL load_match got %b exp 0", bus.o_match); n_fail++;
    end
    n_checks++;
    stream = 4'b0110;
    exp_m  = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      send(stream[3-i]);
      if (bus.o_match !== exp_m[3-i]) begin
        $display("FAIL load_seq bit%0d got %b exp %b", i, bus.o_match, exp_m[3-i]); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    bus.i_overlap = 1'b1;
    send(1'b1);
    send(1'b0);
    send(1'b1);
    do_reset(1);
    if (bus.o_fill !== 3'd0) begin
      $display("FAIL rmid_fill got %0d exp 0", bus.o_fill); n_fail++;
    end
    n_checks++;
    send(1'b1);
    if (bus.o_match !== 1'b0) begin
      $display("FAIL rmid_match got %b exp 0", bus.o_match); n_fail++;
    end
    n_checks++;
    tick();
    if (bus.o_match !== 1'b0) begin
      $display("FAIL rmid_after got %b exp 0", bus.o_match); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_saturation();
    logic [6:0] exp_m;
    logic [1:0] exp_c [7];
    exp_m = 7'b0001111;
    exp_c = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    do_reset(1);
    bus.i_overlap  = 1'b1;
    bus.i_pat      = 4'b1111;
    bus.i_pat_load = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      send(1'b1);
      if (bus.o_match !== exp_m[6-i]) begin
        $display("FAIL sat_match bit%0d got %b exp %b", i, bus.o_match, exp_m[6-i]); n_fail++;
      end
      n_checks++;
      if (bus.o_match_cnt !== exp_c[i]) begin
        $display("FAIL sat_cnt bit%0d got %0d exp %0d", i, bus.o_match_cnt, exp_c[i]); n_fail++;
      end
      n_checks++;
    end
    // Clear on a match edge: pulse still appears, count goes to zero.
    bus.i_cnt_clr = 1'b1;
    send(1'b1);
    bus.i_cnt_clr = 1'b0;
    if (bus.o_match !== 1'b1) begin
      $display("FAIL clr_match got %b exp 1", bus.o_match); n_fail++;
    end
    n_checks++;
    if (bus.o_match_cnt !== 2'd0) begin
      $display("FAIL clr_cnt got %0d exp 0", bus.o_match_cnt); n_fail++;
    end
    n_checks++;
    send(1'b1);
    if (bus.o_match_cnt !== 2'd1) begin
      $display("FAIL clr_recount got %0d exp 1", bus.o_match_cnt); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    bus.i_overlap = 1'b1;
    idle_inputs();
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_reload();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
